// File: rtl/ucpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ucpu_pkg
//  Description : Shared constants and types for the micro-CPU program loader
//                and instruction store.
//  Revision    : 1.0 - initial release
// ============================================================================
package ucpu_pkg;

    // Native instruction word width of the micro-CPU.
    localparam int INST_WIDTH = 32;

    // All-zero word executes as a NOP; returned for unwritten addresses.
    localparam logic [INST_WIDTH-1:0] NOP_INSTR = '0;

    // Loader control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FULL = 2'd2
    } loader_state_t;

endpackage : ucpu_pkg
`default_nettype wire

// File: rtl/instr_mem_array.sv
`default_nettype none
// ============================================================================
//  Module      : instr_mem_array
//  Description : DEPTH x WIDTH instruction storage with a synchronous write
//                port and a registered (one-cycle latency) read port.
//                Contents are intentionally not reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_mem_array
    import ucpu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Write port: a word lands at the edge that carries its last serial bit.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read port: data register only updates on an enabled read, else holds.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule : instr_mem_array
`default_nettype wire

// File: rtl/instr_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : instr_mem_loader
//  Description : Serial program loader (MSB-first bit stream, one bit per
//                clock) feeding an auto-incrementing instruction store, plus
//                the fetch-side read port with word_count masking.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_mem_loader
    import ucpu_pkg::*;
#(
    parameter int INST_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  sys_clk,
    input  logic                  sys_reset,
    input  logic                  load_en,
    input  logic                  instr_in,
    input  logic                  fetch_req,
    input  logic [AW-1:0]         fetch_addr,
    output logic [INST_WIDTH-1:0] fetch_data,
    output logic                  fetch_valid,
    output logic                  load_done,
    output logic [AW:0]           word_count
);

    localparam int              BW         = $clog2(INST_WIDTH);
    localparam logic [BW-1:0]   LAST_BIT   = BW'(INST_WIDTH - 1);
    localparam logic [AW:0]     FULL_COUNT = (AW + 1)'(DEPTH);

    loader_state_t           state_q, state_d;
    logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
    // Only INST_WIDTH-1 bits are kept: the word's last bit is taken straight
    // from instr_in when the word is written.
    logic [INST_WIDTH-2:0]   shift_q, shift_d;
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [AW:0]             word_count_q, word_count_d;
    logic                    load_done_q, load_done_d;
    logic                    fetch_valid_q;
    logic                    fetch_hit_q;

    logic                    mem_we;
    logic [INST_WIDTH-1:0]   mem_wdata;
    logic [INST_WIDTH-1:0]   mem_rdata;
    logic                    fetch_go;
    logic                    fetch_hit;
    logic [AW:0]             word_count_inc;

    assign word_count_inc = word_count_q + (AW + 1)'(1);
    assign mem_wdata      = {shift_q, instr_in};
    assign fetch_hit      = ({1'b0, fetch_addr} < word_count_q);

    // Next-state, datapath updates and fetch acceptance for the loader FSM.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        wr_ptr_d     = wr_ptr_q;
        word_count_d = word_count_q;
        load_done_d  = load_done_q;
        mem_we       = 1'b0;
        fetch_go     = 1'b0;

        case (state_q)
            IDLE: begin
                if (load_en) begin
                    // Start of a load; the first bit is captured this cycle,
                    // and a coincident fetch request loses to the load.
                    state_d      = LOAD;
                    bit_cnt_d    = BW'(1);
                    shift_d      = '0;
                    shift_d[0]   = instr_in;
                    wr_ptr_d     = '0;
                    word_count_d = '0;
                    load_done_d  = 1'b0;
                end else begin
                    fetch_go = fetch_req;
                end
            end

            LOAD: begin
                if (load_en) begin
                    shift_d = (INST_WIDTH - 1)'({shift_q, instr_in});
                    if (bit_cnt_q == LAST_BIT) begin
                        mem_we       = 1'b1;
                        wr_ptr_d     = wr_ptr_q + AW'(1);
                        word_count_d = word_count_inc;
                        bit_cnt_d    = '0;
                        if (word_count_inc == FULL_COUNT) begin
                            state_d     = FULL;
                            load_done_d = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end else begin
                    // Early end of load: any partial word is dropped.
                    state_d     = IDLE;
                    bit_cnt_d   = '0;
                    load_done_d = 1'b1;
                end
            end

            FULL: begin
                // Memory is sealed; serial input ignored, fetches served.
                fetch_go = fetch_req;
                if (!load_en) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Loader state and datapath registers.
    always_ff @(posedge sys_clk or negedge sys_reset) begin
        if (!sys_reset) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            wr_ptr_q     <= '0;
            word_count_q <= '0;
            load_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            wr_ptr_q     <= wr_ptr_d;
            word_count_q <= word_count_d;
            load_done_q  <= load_done_d;
        end
    end

    // Fetch response qualifiers; the hit flag masks stale or unwritten data.
    always_ff @(posedge sys_clk or negedge sys_reset) begin
        if (!sys_reset) begin
            fetch_valid_q <= 1'b0;
            fetch_hit_q   <= 1'b0;
        end else begin
            fetch_valid_q <= fetch_go;
            if (fetch_go) begin
                fetch_hit_q <= fetch_hit;
            end
        end
    end

    instr_mem_array #(
        .WIDTH (INST_WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (sys_clk),
        .we    (mem_we),
        .waddr (wr_ptr_q),
        .wdata (mem_wdata),
        .re    (fetch_go && fetch_hit),
        .raddr (fetch_addr),
        .rdata (mem_rdata)
    );

    assign fetch_data  = fetch_hit_q ? mem_rdata : INST_WIDTH'(NOP_INSTR);
    assign fetch_valid = fetch_valid_q;
    assign load_done   = load_done_q;
    assign word_count  = word_count_q;

endmodule : instr_mem_loader
`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_mem_loader
//  Description : Scoreboard bench for instr_mem_loader. Serial loads are
//                described as bit streams; the expected memory image is
//                rebuilt from the stream. Fetch expectations are queued by
//                the driver and consumed by an independent monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_mem_loader;

    localparam int W     = 32;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          sys_clk   = 1'b0;
    logic          sys_reset = 1'b0;
    logic          load_en   = 1'b0;
    logic          instr_in  = 1'b0;
    logic          fetch_req = 1'b0;
    logic [AW-1:0] fetch_addr = '0;
    logic [W-1:0]  fetch_data;
    logic          fetch_valid;
    logic          load_done;
    logic [AW:0]   word_count;

    always #5 sys_clk = ~sys_clk;

    instr_mem_loader #(
        .INST_WIDTH (W),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_reset   (sys_reset),
        .load_en     (load_en),
        .instr_in    (instr_in),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_data  (fetch_data),
        .fetch_valid (fetch_valid),
        .load_done   (load_done),
        .word_count  (word_count)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: program image and number of valid words.
    logic [W-1:0] model_mem [DEPTH];
    int           model_count = 0;
    bit           stream [$];
    logic [W-1:0] exp_q [$];
    logic [W-1:0] last_data = '0;
    logic [W-1:0] mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one expected response per queued fetch, else outputs idle/hold.
    always @(posedge sys_clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("fetch_valid", {31'd0, fetch_valid}, 32'd1);
            check("fetch_data", fetch_data, mon_e);
            last_data = mon_e;
        end else begin
            check("no_fetch_valid", {31'd0, fetch_valid}, 32'd0);
            check("fetch_data_hold", fetch_data, last_data);
        end
    end

    task automatic push_word(input logic [W-1:0] w);
        for (int b = W - 1; b >= 0; b--) stream.push_back(w[b]);
    endtask

    task automatic push_bits(input int n, input bit ones);
        for (int b = 0; b < n; b++) stream.push_back(ones ? 1'b1 : 1'($urandom_range(0, 1)));
    endtask

    task automatic issue_fetch(input int addr);
        @(negedge sys_clk);
        fetch_req  = 1'b1;
        fetch_addr = AW'(addr);
        if (addr < model_count) exp_q.push_back(model_mem[addr]);
        else                    exp_q.push_back('0);
    endtask

    task automatic end_fetch();
        @(negedge sys_clk);
        fetch_req = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        #2;
        sys_reset = 1'b0;
        exp_q.delete();
        last_data   = '0;
        model_count = 0;
        #1;
        check("rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
        check("rst_fetch_data", fetch_data, 32'd0);
        check("rst_load_done", {31'd0, load_done}, 32'd0);
        check("rst_word_count", {27'd0, word_count}, 32'd0);
        load_en   = 1'b0;
        fetch_req = 1'b0;
        repeat (2) @(negedge sys_clk);
        sys_reset = 1'b1;
    endtask

    // Shift the current stream in; optionally request fetches during it or
    // abort the load with a reset instead of dropping load_en.
    task automatic run_load(input bit fetch_during, input bit abort);
        int nbits;
        int nwords;
        logic [W-1:0] wv;
        nbits = stream.size();
        for (int i = 0; i < nbits; i++) begin
            @(negedge sys_clk);
            if (i == 1) begin
                check("load_done_falls", {31'd0, load_done}, 32'd0);
                check("word_count_clears", {27'd0, word_count}, 32'd0);
            end
            load_en  = 1'b1;
            instr_in = stream[i];
            // Requests are only made while still in LOAD (before the memory fills).
            if (fetch_during && i < DEPTH * W) begin
                fetch_req  = 1'b1;
                fetch_addr = AW'($urandom_range(0, DEPTH - 1));
            end else begin
                fetch_req = 1'b0;
            end
        end
        if (abort) begin
            stream.delete();
            do_reset();
            return;
        end
        nwords = nbits / W;
        if (nwords > DEPTH) nwords = DEPTH;
        @(negedge sys_clk);
        check("word_count_in_load", {27'd0, word_count}, 32'(nwords));
        check("load_done_in_load", {31'd0, load_done}, {31'd0, nwords == DEPTH});
        load_en   = 1'b0;
        instr_in  = 1'b0;
        fetch_req = 1'b0;
        for (int k = 0; k < nwords; k++) begin
            wv = '0;
            for (int b = 0; b < W; b++) wv = {wv[W-2:0], 1'(stream[k * W + b])};
            model_mem[k] = wv;
        end
        model_count = nwords;
        stream.delete();
        @(negedge sys_clk);
        check("word_count_after", {27'd0, word_count}, 32'(model_count));
        check("load_done_after", {31'd0, load_done}, 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int nw;
        int ex;
        repeat (3) @(negedge sys_clk);
        check("reset_fetch_valid", {31'd0, fetch_valid}, 32'd0);
        check("reset_fetch_data", fetch_data, 32'd0);
        check("reset_load_done", {31'd0, load_done}, 32'd0);
        check("reset_word_count", {27'd0, word_count}, 32'd0);

        // Release with a fetch pending: empty program reads as NOP.
        @(negedge sys_clk);
        sys_reset  = 1'b1;
        fetch_req  = 1'b1;
        fetch_addr = '0;
        exp_q.push_back('0);
        @(negedge sys_clk);
        fetch_req = 1'b0;
        check("idle_load_done", {31'd0, load_done}, 32'd0);
        check("idle_word_count", {27'd0, word_count}, 32'd0);

        // Single word.
        push_word(32'hABCD1234);
        run_load(1'b0, 1'b0);
        issue_fetch(0);
        end_fetch();

        // Three words plus a discarded partial word.
        push_word(32'h00000013);
        push_word(32'hDEADBEEF);
        push_word(32'h12345678);
        push_bits(10, 1'b0);
        run_load(1'b0, 1'b0);
        issue_fetch(3);
        issue_fetch(2);
        issue_fetch(0);
        issue_fetch(1);
        end_fetch();

        // Fill the memory, then keep clocking ones into FULL.
        for (int k = 0; k < DEPTH; k++) push_word(32'h1000_0000 + 32'(k));
        push_bits(64, 1'b1);
        run_load(1'b0, 1'b0);
        issue_fetch(15);
        for (int a = 0; a < DEPTH; a++) issue_fetch(a);
        end_fetch();

        // Fetch requests held through a second load (including its first cycle).
        push_word(32'hCAFEF00D);
        push_word(32'h0BADC0DE);
        run_load(1'b1, 1'b0);
        issue_fetch(1);
        issue_fetch(2);
        end_fetch();

        // Reset partway through word 2, then a fresh single-word load.
        push_word(32'h55AA55AA);
        push_bits(17, 1'b0);
        run_load(1'b0, 1'b1);
        issue_fetch(0);
        end_fetch();
        check("post_rst_load_done", {31'd0, load_done}, 32'd0);
        push_word(32'hABCD1234);
        run_load(1'b0, 1'b0);
        issue_fetch(0);
        issue_fetch(1);
        end_fetch();

        // Randomized loads with random fetch traffic.
        for (int it = 0; it < 25; it++) begin
            nw = $urandom_range(0, DEPTH + 2);
            ex = $urandom_range(0, W - 1);
            if (nw == 0 && ex < 2) ex = 2;
            for (int k = 0; k < nw; k++) push_word($urandom);
            push_bits(ex, 1'b0);
            run_load(1'($urandom_range(0, 1)), 1'b0);
            for (int f = 0; f < 6; f++) begin
                issue_fetch($urandom_range(0, DEPTH - 1));
                if ($urandom_range(0, 2) == 0) end_fetch();
            end
            end_fetch();
        end

        repeat (3) @(negedge sys_clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_instr_mem_loader
`default_nettype wire
